// File: rtl/protocol_tx.sv
// Serial transmitter for the lamp LED dck/cs/mosi link: one frame per start,
// command and length header followed by payload bytes, all MSB first.
module protocol_tx #(
    parameter int unsigned c_half_period  = 4,
    parameter int unsigned c_command_bits = 5,
    parameter int unsigned c_length_bits  = 11
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [c_command_bits-1:0] i_command,
    input  logic [c_length_bits-1:0]  i_length,
    input  logic [7:0]                i_byte,
    input  logic                      i_byte_valid,
    output logic                      o_byte_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_dck,
    output logic                      o_cs,
    output logic                      o_mosi
);
    localparam int unsigned c_div_w = $clog2(c_half_period + 1);
    localparam int unsigned c_cnt_w = c_length_bits + 4;
    localparam int unsigned c_hdr_w = c_command_bits + c_length_bits;
    localparam int unsigned c_pad_w = c_hdr_w - 8;
    localparam logic [c_div_w-1:0] c_div_load = c_div_w'(c_half_period - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_STALL, S_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [c_div_w-1:0]       div_q, div_d;
    logic [c_cnt_w-1:0]       cnt_q, cnt_d;
    logic [c_hdr_w-1:0]       shift_q, shift_d;
    logic [7:0]               hold_q, hold_d;
    logic                     hold_full_q, hold_full_d;
    logic [c_length_bits-1:0] len_q, len_d, acc_q, acc_d;
    logic                     cs_q, dck_q, busy_q, done_q;
    logic                     cs_d, dck_d, busy_d, done_d;

    logic                     accept_c, avail_c, boundary_c;
    logic [7:0]               take_byte_c;
    logic [c_cnt_w-1:0]       cnt_inc_c, total_c;
    logic [2:0]               past_hdr_c;

    assign o_byte_ready = busy_q && !hold_full_q && (acc_q < len_q);
    assign accept_c     = o_byte_ready && i_byte_valid;
    // A byte for the next boundary comes from the holding register, or straight from the stream
    assign avail_c      = hold_full_q || accept_c;
    assign take_byte_c  = hold_full_q ? hold_q : i_byte;
    assign total_c      = c_cnt_w'({len_q, 3'b000}) + c_cnt_w'(c_hdr_w);
    assign cnt_inc_c    = cnt_q + c_cnt_w'(1);
    assign past_hdr_c   = 3'(cnt_inc_c - c_cnt_w'(c_hdr_w));
    assign boundary_c   = (cnt_inc_c >= c_cnt_w'(c_hdr_w)) && (past_hdr_c == 3'b000);

    assign o_mosi = shift_q[c_hdr_w-1];
    assign o_cs   = cs_q;
    assign o_dck  = dck_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        len_d       = len_q;
        acc_d       = acc_q;

        if (accept_c) begin
            acc_d       = acc_q + c_length_bits'(1);
            hold_d      = i_byte;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start && (i_length != '0)) begin
                    state_d     = S_SETUP;
                    div_d       = c_div_load;
                    cnt_d       = '0;
                    shift_d     = {i_command, i_length};
                    len_d       = i_length;
                    acc_d       = '0;
                    hold_full_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (div_q == '0) begin
                    state_d = S_HIGH;
                    div_d   = c_div_load;
                end else begin
                    div_d = div_q - c_div_w'(1);
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    div_d = c_div_load;
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == total_c) begin
                        state_d = S_LOW;
                    end else if (boundary_c) begin
                        if (avail_c) begin
                            state_d     = S_LOW;
                            shift_d     = {take_byte_c, {c_pad_w{1'b0}}};
                            hold_full_d = 1'b0;
                        end else begin
                            state_d = S_STALL;
                        end
                    end else begin
                        state_d = S_LOW;
                        shift_d = {shift_q[c_hdr_w-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q - c_div_w'(1);
                end
            end
            S_STALL: begin
                if (avail_c) begin
                    state_d     = S_LOW;
                    div_d       = c_div_load;
                    shift_d     = {take_byte_c, {c_pad_w{1'b0}}};
                    hold_full_d = 1'b0;
                end
            end
            S_LOW: begin
                if (div_q == '0) begin
                    div_d = c_div_load;
                    if (cnt_q == total_c) begin
                        state_d = S_FINISH;
                        shift_d = '0;
                    end else begin
                        state_d = S_HIGH;
                    end
                end else begin
                    div_d = div_q - c_div_w'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        cs_d   = (state_d == S_IDLE) || (state_d == S_FINISH);
        dck_d  = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            len_q       <= '0;
            acc_q       <= '0;
            cs_q        <= 1'b1;
            dck_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            cs_q        <= cs_d;
            dck_q       <= dck_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule
